ps2_dev_tx: RTL and testbench

Multi-channel PS/2 device-side transmitter for the MiST cores. It buffers bytes delivered by the IO-controller command decoder (keyboard, mouse or extra devices) and serialises them onto emulated PS/2 clock/data lines. Unlike the older fixed two-channel scheme, it has a parametrised channel count and FIFO depth and generates its own PS/2 clock from `clk_sys`. It honours host inhibit, and it removes a byte from its FIFO only after the stop bit has been sent.

---
 rtl/ps2_pkg.sv | 40 ++++
 rtl/ps2_tx_chan.sv | 159 +++++++++++++++
 rtl/ps2_dev_tx.sv | 66 ++++++
 tb/tb_ps2_dev_tx.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared state encoding, frame constants and bit helpers for the
//            PS/2 device-side transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HIGH  = 3'd1,
        S_LOW   = 3'd2,
        S_GAP   = 3'd3,
        S_INHIB = 3'd4
    } tx_state_t;

    localparam int c_FRAME_LEN = 11;
    localparam int c_GAP_LEN   = 2;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    // Bit idx of the 11-bit frame: start, data LSB first, parity, stop.
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
        logic r;
        r = 1'b1;
        if (idx == 4'd0) begin
            r = 1'b0;
        end else if (idx <= 4'd8) begin
            r = b[3'(idx - 4'd1)];
        end else if (idx == 4'd9) begin
            r = odd_parity(b);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_tx_chan.sv
`default_nettype none
// ============================================================================
// Module   : ps2_tx_chan
// Purpose  : One PS/2 device transmit channel: byte FIFO, host-clock
//            synchroniser and the frame serialiser FSM.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_tx_chan
    import ps2_pkg::*;
#(
    parameter int FIFO_BITS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tick,
    input  logic       i_wr_stb,
    input  logic [7:0] i_wr_data,
    input  logic       i_ovf_clr,
    input  logic       i_ps2_clk_in,
    output logic       o_ps2_clk_out,
    output logic       o_ps2_data_out,
    output logic       o_fifo_empty,
    output logic       o_fifo_full,
    output logic       o_overflow,
    output logic       o_busy
);

    localparam int              c_DEPTH    = 1 << FIFO_BITS;
    localparam logic [3:0]      c_LAST_BIT = 4'(c_FRAME_LEN - 1);
    localparam logic [1:0]      c_GAP_INIT = 2'(c_GAP_LEN - 2);

    logic [7:0]         r_mem [c_DEPTH];
    logic [FIFO_BITS:0] r_wr_ptr;
    logic [FIFO_BITS:0] r_rd_ptr;
    logic               r_overflow;
    logic [1:0]         r_sync;
    tx_state_t          r_state;
    logic [3:0]         r_bit_idx;
    logic [7:0]         r_byte;
    logic [1:0]         r_gap_cnt;
    logic               r_clk_out;
    logic               r_data_out;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_line_hi;
    logic [7:0]         w_head;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[FIFO_BITS] != r_rd_ptr[FIFO_BITS]) &&
                       (r_wr_ptr[FIFO_BITS-1:0] == r_rd_ptr[FIFO_BITS-1:0]);
    assign w_push    = i_wr_stb && !w_full;
    assign w_pop     = i_tick && (r_state == S_LOW) && (r_bit_idx == c_LAST_BIT);
    assign w_line_hi = r_sync[1];
    assign w_head    = r_mem[r_rd_ptr[FIFO_BITS-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[FIFO_BITS-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            r_sync     <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_ps2_clk_in};
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            // A dropped write outranks a simultaneous clear.
            if (i_wr_stb && w_full) begin
                r_overflow <= 1'b1;
            end else if (i_ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bit_idx  <= 4'd0;
            r_byte     <= 8'h00;
            r_gap_cnt  <= 2'd0;
            r_clk_out  <= 1'b1;
            r_data_out <= 1'b1;
        end else if (i_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty && w_line_hi) begin
                        r_byte     <= w_head;
                        r_bit_idx  <= 4'd0;
                        r_data_out <= frame_bit(w_head, 4'd0);
                        r_clk_out  <= 1'b1;
                        r_state    <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    // Once the stop bit is on the line the byte is committed.
                    if (!w_line_hi && (r_bit_idx < c_LAST_BIT)) begin
                        r_clk_out  <= 1'b1;
                        r_data_out <= 1'b1;
                        r_state    <= S_INHIB;
                    end else begin
                        r_clk_out <= 1'b0;
                        r_state   <= S_LOW;
                    end
                end
                S_LOW: begin
                    r_clk_out <= 1'b1;
                    if (r_bit_idx == c_LAST_BIT) begin
                        r_data_out <= 1'b1;
                        r_gap_cnt  <= c_GAP_INIT;
                        r_state    <= S_GAP;
                    end else begin
                        r_bit_idx  <= r_bit_idx + 4'd1;
                        r_data_out <= frame_bit(r_byte, r_bit_idx + 4'd1);
                        r_state    <= S_HIGH;
                    end
                end
                S_GAP: begin
                    // Gap is measured from the pop tick, so the next start
                    // can follow exactly two ticks later.
                    if (r_gap_cnt == 2'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 2'd1;
                    end
                end
                S_INHIB: begin
                    if (w_line_hi) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ps2_clk_out  = r_clk_out;
    assign o_ps2_data_out = r_data_out;
    assign o_fifo_empty   = w_empty;
    assign o_fifo_full    = w_full;
    assign o_overflow     = r_overflow;
    assign o_busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: rtl/ps2_dev_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_dev_tx
// Purpose  : Multi-channel PS/2 device-side transmitter with a shared
//            PS/2 bit-clock divider.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_dev_tx #(
    parameter int CHANNELS  = 2,
    parameter int FIFO_BITS = 3,
    parameter int CLK_DIV   = 1000
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic [CHANNELS-1:0]   wr_stb,
    input  logic [8*CHANNELS-1:0] wr_data,
    input  logic [CHANNELS-1:0]   ovf_clr,
    input  logic [CHANNELS-1:0]   ps2_clk_in,
    output logic [CHANNELS-1:0]   ps2_clk_out,
    output logic [CHANNELS-1:0]   ps2_data_out,
    output logic [CHANNELS-1:0]   fifo_empty,
    output logic [CHANNELS-1:0]   fifo_full,
    output logic [CHANNELS-1:0]   overflow,
    output logic [CHANNELS-1:0]   busy
);

    localparam int                 c_DIV_W   = $clog2(CLK_DIV);
    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(CLK_DIV - 1);

    logic [c_DIV_W-1:0] r_div_cnt;
    logic               w_tick;

    assign w_tick = (r_div_cnt == c_DIV_MAX);

    always_ff @(posedge clk_sys) begin
        if (reset || w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            ps2_tx_chan #(
                .FIFO_BITS (FIFO_BITS)
            ) u_chan (
                .clk            (clk_sys),
                .rst            (reset),
                .i_tick         (w_tick),
                .i_wr_stb       (wr_stb[gi]),
                .i_wr_data      (wr_data[8*gi +: 8]),
                .i_ovf_clr      (ovf_clr[gi]),
                .i_ps2_clk_in   (ps2_clk_in[gi]),
                .o_ps2_clk_out  (ps2_clk_out[gi]),
                .o_ps2_data_out (ps2_data_out[gi]),
                .o_fifo_empty   (fifo_empty[gi]),
                .o_fifo_full    (fifo_full[gi]),
                .o_overflow     (overflow[gi]),
                .o_busy         (busy[gi])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ps2_dev_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_dev_tx
// Purpose  : Self-checking bench for ps2_dev_tx (2 channels, CLK_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_dev_tx;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [1:0]  wr_stb;
    logic [15:0] wr_data;
    logic [1:0]  ovf_clr;
    logic [1:0]  ps2_clk_in;
    logic [1:0]  ps2_clk_out;
    logic [1:0]  ps2_data_out;
    logic [1:0]  fifo_empty;
    logic [1:0]  fifo_full;
    logic [1:0]  overflow;
    logic [1:0]  busy;
    logic [1:0]  host_rel;

    // Wire-AND of device drive and host drive.
    assign ps2_clk_in = ps2_clk_out & host_rel;

    always #5 clk_sys = ~clk_sys;

    ps2_dev_tx #(
        .CHANNELS  (2),
        .FIFO_BITS (3),
        .CLK_DIV   (4)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .wr_stb       (wr_stb),
        .wr_data      (wr_data),
        .ovf_clr      (ovf_clr),
        .ps2_clk_in   (ps2_clk_in),
        .ps2_clk_out  (ps2_clk_out),
        .ps2_data_out (ps2_data_out),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .overflow     (overflow),
        .busy         (busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Host-side frame receiver: samples data on each falling device clock.
    logic [1:0]  prev_clk = 2'b11;
    int          nbits [2];
    int          falls [2];
    logic [10:0] shreg [2];
    logic [10:0] last_frame [2];
    logic [7:0]  rx0 [$];
    logic [7:0]  rx1 [$];
    int          st0 [$];
    int          st1 [$];

    always @(negedge clk_sys) begin
        for (int c = 0; c < 2; c++) begin
            if (reset || !busy[c]) begin
                nbits[c] = 0;
            end else if (prev_clk[c] && !ps2_clk_out[c]) begin
                falls[c]++;
                if (nbits[c] == 0) begin
                    if (c == 0) st0.push_back(cyc);
                    else        st1.push_back(cyc);
                end
                shreg[c][nbits[c]] = ps2_data_out[c];
                nbits[c]++;
                if (nbits[c] == 11) begin
                    last_frame[c] = shreg[c];
                    check("frame_format", {29'd0, ~shreg[c][0], ^shreg[c][9:1], shreg[c][10]}, 32'd7);
                    if (c == 0) rx0.push_back(shreg[c][8:1]);
                    else        rx1.push_back(shreg[c][8:1]);
                    nbits[c] = 0;
                end
            end
            prev_clk[c] = ps2_clk_out[c];
        end
    end

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic wr1(input int ch, input logic [7:0] v);
        wr_stb[ch]          = 1'b1;
        wr_data[8*ch +: 8]  = v;
        @(negedge clk_sys);
        wr_stb = 2'b00;
    endtask

    task automatic wait_idle(input logic [1:0] m, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_sys);
            if (((fifo_empty & m) == m) && ((busy & m) == 2'b00)) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_bits(input int ch, input int n, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_sys);
            if (nbits[ch] >= n) begin
                ok = 1'b1;
                break;
            end
        end
        check("bits_timeout", {31'd0, ok}, 32'd1);
    endtask

    typedef struct {
        int          ch;
        logic [7:0]  b;
        logic [10:0] frame;   // bit k = k-th bit on the wire
    } vec_t;

    vec_t        tbl [6];
    int          f0;
    int          t0;
    int          nb0;
    int          nb1;
    bit          ok;
    logic [7:0]  v0;
    logic [7:0]  v1;
    logic [7:0]  e0 [$];
    logic [7:0]  e1 [$];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 8'h1C, {1'b1, 1'b0, 8'h1C, 1'b0}};
        tbl[1] = '{1, 8'h00, {1'b1, 1'b1, 8'h00, 1'b0}};
        tbl[2] = '{0, 8'hFF, {1'b1, 1'b1, 8'hFF, 1'b0}};
        tbl[3] = '{1, 8'h80, {1'b1, 1'b0, 8'h80, 1'b0}};
        tbl[4] = '{0, 8'hA5, {1'b1, 1'b1, 8'hA5, 1'b0}};
        tbl[5] = '{1, 8'h37, {1'b1, 1'b0, 8'h37, 1'b0}};

        reset    = 1'b1;
        wr_stb   = 2'b00;
        wr_data  = 16'h0000;
        ovf_clr  = 2'b00;
        host_rel = 2'b11;
        tick_n(3);
        reset = 1'b0;
        tick_n(1);
        check("rst_clk_out",  {30'd0, ps2_clk_out},  32'd3);
        check("rst_data_out", {30'd0, ps2_data_out}, 32'd3);
        check("rst_empty",    {30'd0, fifo_empty},   32'd3);
        check("rst_full",     {30'd0, fifo_full},    32'd0);
        check("rst_overflow", {30'd0, overflow},     32'd0);
        check("rst_busy",     {30'd0, busy},         32'd0);
        tick_n(4);

        // Single bytes from the vector table.
        for (int i = 0; i < 6; i++) begin
            rx0.delete();
            rx1.delete();
            f0 = falls[tbl[i].ch];
            wr1(tbl[i].ch, tbl[i].b);
            check("empty_after_wr", {31'd0, fifo_empty[tbl[i].ch]}, 32'd0);
            ok = 1'b0;
            for (int k = 0; k < 20; k++) begin
                if (!ps2_data_out[tbl[i].ch]) begin ok = 1'b1; break; end
                @(negedge clk_sys);
            end
            check("start_timeout", {31'd0, ok}, 32'd1);
            t0 = cyc;
            ok = 1'b0;
            for (int k = 0; k < 200; k++) begin
                if (fifo_empty[tbl[i].ch]) begin ok = 1'b1; break; end
                @(negedge clk_sys);
            end
            check("pop_timeout", {31'd0, ok}, 32'd1);
            check("pop_latency", 32'(cyc - t0), 32'd88);
            wait_idle(2'b11, 100);
            check("falls_per_byte", 32'(falls[tbl[i].ch] - f0), 32'd11);
            check("frame_bits", {21'd0, last_frame[tbl[i].ch]}, {21'd0, tbl[i].frame});
        end

        // Fill to full, drop the 9th write, overflow set/clear priority.
        rx0.delete();
        st0.delete();
        for (int k = 1; k <= 9; k++) begin
            wr_stb[0]    = 1'b1;
            wr_data[7:0] = 8'(k);
            @(negedge clk_sys);
            if (k == 8) begin
                check("full_after_8",  {31'd0, fifo_full[0]}, 32'd1);
                check("no_ovf_at_8",   {31'd0, overflow[0]},  32'd0);
            end
        end
        wr_stb = 2'b00;
        check("ovf_after_9",  {31'd0, overflow[0]},  32'd1);
        check("full_after_9", {31'd0, fifo_full[0]}, 32'd1);
        wr_stb[0]    = 1'b1;
        wr_data[7:0] = 8'h0A;
        ovf_clr[0]   = 1'b1;
        @(negedge clk_sys);
        wr_stb  = 2'b00;
        ovf_clr = 2'b00;
        check("ovf_set_wins", {31'd0, overflow[0]}, 32'd1);
        ovf_clr[0] = 1'b1;
        @(negedge clk_sys);
        ovf_clr = 2'b00;
        check("ovf_cleared", {31'd0, overflow[0]}, 32'd0);
        wait_idle(2'b01, 1500);
        check("ovf_rx_count", 32'(rx0.size()), 32'd8);
        for (int i = 0; i < rx0.size() && i < 8; i++)
            check("ovf_rx_byte", {24'd0, rx0[i]}, 32'(i + 1));
        for (int i = 1; i < st0.size() && i < 8; i++)
            check("start_to_start", 32'(st0[i] - st0[i-1]), 32'd96);

        // Host inhibit mid-byte on channel 1.
        rx1.delete();
        f0 = falls[1];
        wr1(1, 8'hAA);
        wait_bits(1, 4, 100);
        tick_n(3);
        host_rel[1] = 1'b0;
        tick_n(10);
        check("inhib_clk_rel",  {31'd0, ps2_clk_out[1]},  32'd1);
        check("inhib_data_rel", {31'd0, ps2_data_out[1]}, 32'd1);
        check("inhib_busy",     {31'd0, busy[1]},         32'd1);
        check("inhib_no_pop",   {31'd0, fifo_empty[1]},   32'd0);
        tick_n(40);
        host_rel[1] = 1'b1;
        wait_idle(2'b10, 400);
        check("inhib_rx_count", 32'(rx1.size()), 32'd1);
        if (rx1.size() > 0) check("inhib_rx_byte", {24'd0, rx1[0]}, 32'hAA);
        check("inhib_falls", 32'(falls[1] - f0), 32'd15);

        // Inhibit while idle: nothing may start.
        rx0.delete();
        host_rel[0] = 1'b0;
        tick_n(5);
        f0 = falls[0];
        wr1(0, 8'h3C);
        tick_n(60);
        check("idle_inhib_busy",  {31'd0, busy[0]},         32'd0);
        check("idle_inhib_data",  {31'd0, ps2_data_out[0]}, 32'd1);
        check("idle_inhib_falls", 32'(falls[0] - f0),       32'd0);
        host_rel[0] = 1'b1;
        wait_idle(2'b01, 300);
        check("idle_inhib_rx", {24'd0, (rx0.size() > 0) ? rx0[0] : 8'h00}, 32'h3C);

        // Inhibit during the stop bit: byte completes and is popped.
        rx0.delete();
        f0 = falls[0];
        wr1(0, 8'h96);
        wait_bits(0, 10, 200);
        tick_n(3);
        host_rel[0] = 1'b0;
        wait_idle(2'b01, 200);
        tick_n(30);
        host_rel[0] = 1'b1;
        tick_n(20);
        check("stop_inhib_rx",    {24'd0, (rx0.size() > 0) ? rx0[0] : 8'h00}, 32'h96);
        check("stop_inhib_falls", 32'(falls[0] - f0), 32'd11);
        check("stop_inhib_empty", {31'd0, fifo_empty[0]}, 32'd1);

        // Two channels written in the same cycle.
        rx0.delete(); rx1.delete(); st0.delete(); st1.delete();
        wr_stb  = 2'b11;
        wr_data = {8'hF0, 8'h55};
        @(negedge clk_sys);
        wr_stb = 2'b00;
        wait_idle(2'b11, 400);
        check("dual_rx0", {24'd0, (rx0.size() > 0) ? rx0[0] : 8'h00}, 32'h55);
        check("dual_rx1", {24'd0, (rx1.size() > 0) ? rx1[0] : 8'h00}, 32'hF0);
        check("dual_align", 32'((st0.size() > 0) ? st0[0] : -1), 32'((st1.size() > 0) ? st1[0] : -2));

        // Randomized bursts against a capacity-8 queue model.
        for (int r = 0; r < 5; r++) begin
            rx0.delete(); rx1.delete(); e0.delete(); e1.delete();
            nb0 = $urandom_range(0, 11);
            nb1 = $urandom_range(0, 11);
            for (int k = 0; k < 11; k++) begin
                v0 = 8'($urandom);
                v1 = 8'($urandom);
                wr_stb  = {k < nb1, k < nb0};
                wr_data = {v1, v0};
                if (k < nb0 && e0.size() < 8) e0.push_back(v0);
                if (k < nb1 && e1.size() < 8) e1.push_back(v1);
                @(negedge clk_sys);
            end
            wr_stb = 2'b00;
            check("rnd_ovf0", {31'd0, overflow[0]}, {31'd0, nb0 > 8});
            check("rnd_ovf1", {31'd0, overflow[1]}, {31'd0, nb1 > 8});
            wait_idle(2'b11, 1500);
            check("rnd_cnt0", 32'(rx0.size()), 32'(e0.size()));
            check("rnd_cnt1", 32'(rx1.size()), 32'(e1.size()));
            for (int i = 0; i < e0.size() && i < rx0.size(); i++)
                check("rnd_byte0", {24'd0, rx0[i]}, {24'd0, e0[i]});
            for (int i = 0; i < e1.size() && i < rx1.size(); i++)
                check("rnd_byte1", {24'd0, rx1[i]}, {24'd0, e1[i]});
            ovf_clr = 2'b11;
            @(negedge clk_sys);
            ovf_clr = 2'b00;
        end

        // Reset in the middle of a frame with more data queued.
        wr1(0, 8'h5A);
        wr1(0, 8'h11);
        wait_bits(0, 6, 200);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        check("mid_rst_clk",   {30'd0, ps2_clk_out},  32'd3);
        check("mid_rst_data",  {30'd0, ps2_data_out}, 32'd3);
        check("mid_rst_empty", {30'd0, fifo_empty},   32'd3);
        check("mid_rst_full",  {30'd0, fifo_full},    32'd0);
        check("mid_rst_busy",  {30'd0, busy},         32'd0);
        f0 = falls[0];
        tick_n(200);
        check("post_rst_falls", 32'(falls[0] - f0), 32'd0);
        check("post_rst_busy",  {30'd0, busy},      32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
